// File: rtl/reg_bus_resp_slice_pkg.sv
// reg_bus_resp_slice_pkg: shared state and bus types for the register-bus response slice
package reg_bus_resp_slice_pkg;
    localparam int DW = 32;
    localparam int AW = 32;
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW/8-1:0] wstrb;
    } req_t;
    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          error;
    } rsp_t;
endpackage

// File: rtl/reg_bus_resp_slice_if.sv
// reg_bus_resp_slice_if: register-bus request/response bundle with master and slave views
interface reg_bus_resp_slice_if
    import reg_bus_resp_slice_pkg::*;
#(
    parameter int DataWidth = DW,
    parameter int AddrWidth = AW
);
    logic                   valid;
    logic                   write;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   ready;
    logic [DataWidth-1:0]   rdata;
    logic                   error;
    modport master (output valid, write, addr, wdata, wstrb, input ready, rdata, error);
    modport slave  (input valid, write, addr, wdata, wstrb, output ready, rdata, error);
endinterface

// File: rtl/reg_bus_timeout_cnt.sv
// reg_bus_timeout_cnt: clearable cycle counter flagging the last allowed wait cycle
module reg_bus_timeout_cnt #(
    parameter int TimeoutCycles = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TimeoutCycles + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign expired = en && (cnt == W'(TimeoutCycles - 1));
endmodule

// File: rtl/reg_bus_resp_slice.sv
// reg_bus_resp_slice: registered reg-bus cut with misalign rejection; REG_BUS_RESP_SLICE_TIMEOUT_EN adds abort
module reg_bus_resp_slice
    import reg_bus_resp_slice_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input logic                  clk_i,
    input logic                  rst_i,
    reg_bus_resp_slice_if.slave  slv,
    reg_bus_resp_slice_if.master mst
);
    localparam int OW = $clog2(DataWidth / 8);
    state_e                 state;
    logic                   write;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic [DataWidth-1:0]   rdata;
    logic                   error;
    logic                   timeout;
`ifdef REG_BUS_RESP_SLICE_TIMEOUT_EN
    reg_bus_timeout_cnt #(.TimeoutCycles(TimeoutCycles)) u_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (state == IDLE),
        .en      (state == REQ && !mst.ready),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk_i)
        if (rst_i) begin
            state <= IDLE;
            write <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            wstrb <= '0;
            rdata <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                IDLE: if (slv.valid) begin
                    write <= slv.write;
                    addr  <= slv.addr;
                    wdata <= slv.wdata;
                    wstrb <= slv.wstrb;
                    if (slv.addr[OW-1:0] != '0) begin
                        rdata <= '0;
                        error <= 1'b1;
                        state <= RSP;
                    end else state <= REQ;
                end
                REQ: if (mst.ready) begin
                    // write responses pass rdata through untouched; only failed reads are zeroed
                    rdata <= (mst.error && !write) ? '0 : mst.rdata;
                    error <= mst.error;
                    state <= RSP;
                end else if (timeout) begin
                    rdata <= '0;
                    error <= 1'b1;
                    state <= RSP;
                end
                default: state <= IDLE;
            endcase
        end
    assign slv.ready = state == RSP;
    assign slv.rdata = rdata;
    assign slv.error = error;
    assign mst.valid = state == REQ;
    assign mst.write = write;
    assign mst.addr  = addr;
    assign mst.wdata = wdata;
    assign mst.wstrb = wstrb;
endmodule

// File: tb/tb_reg_bus_resp_slice.sv
// tb_reg_bus_resp_slice: directed checks of latency, misalign, error zeroing and reset
module tb_reg_bus_resp_slice;
    logic clk = 0;
    logic rst = 1;
    int   n_tests = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    reg_bus_resp_slice_if #(.DataWidth(32), .AddrWidth(32)) slv_if ();
    reg_bus_resp_slice_if #(.DataWidth(32), .AddrWidth(32)) mst_if ();
    reg_bus_resp_slice #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .slv   (slv_if),
        .mst   (mst_if)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_slv_ready"}, 32'(slv_if.ready), 32'd0);
        chk({tag, "_slv_rdata"}, slv_if.rdata, 32'd0);
        chk({tag, "_slv_error"}, 32'(slv_if.error), 32'd0);
        chk({tag, "_mst_valid"}, 32'(mst_if.valid), 32'd0);
        chk({tag, "_mst_write"}, 32'(mst_if.write), 32'd0);
        chk({tag, "_mst_addr"}, mst_if.addr, 32'd0);
        chk({tag, "_mst_wdata"}, mst_if.wdata, 32'd0);
        chk({tag, "_mst_wstrb"}, 32'(mst_if.wstrb), 32'd0);
    endtask
    // cycle 0 is the first cycle slv valid is high; slave answers on REQ cycle lat+1
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int lat, input logic [31:0] rd, input logic re,
                        output int cyc, output logic [31:0] got_d, output logic got_e,
                        output int nreq, output logic stab);
        @(posedge clk); #1;
        slv_if.valid = 1; slv_if.write = w; slv_if.addr = a; slv_if.wdata = d; slv_if.wstrb = s;
        cyc = 0; nreq = 0; stab = 1; got_d = 'x; got_e = 'x;
        while (cyc < 50) begin
            @(negedge clk);
            if (slv_if.ready) begin
                got_d = slv_if.rdata;
                got_e = slv_if.error;
                break;
            end
            if (mst_if.valid) begin
                nreq++;
                if (mst_if.write !== w || mst_if.addr !== a || mst_if.wdata !== d || mst_if.wstrb !== s) stab = 0;
                mst_if.ready = (nreq == lat + 1);
                mst_if.rdata = rd;
                mst_if.error = re;
            end
            @(posedge clk); #1;
            mst_if.ready = 0;
            cyc++;
        end
        slv_if.valid = 0;
    endtask
    int          cyc, nreq;
    logic [31:0] rd;
    logic        er, st;
    initial begin
        slv_if.valid = 0; slv_if.write = 0; slv_if.addr = 0; slv_if.wdata = 0; slv_if.wstrb = 0;
        mst_if.ready = 0; mst_if.rdata = 0; mst_if.error = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_idle_outputs("reset");
        mst_if.ready = 1; mst_if.rdata = 32'hFFFF_FFFF; mst_if.error = 1;
        repeat (2) @(negedge clk);
        chk("stray_ready_slv", 32'(slv_if.ready), 32'd0);
        chk("stray_ready_mst", 32'(mst_if.valid), 32'd0);
        mst_if.ready = 0; mst_if.error = 0;
        xfer(0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0, cyc, rd, er, nreq, st);
        chk("rd_lat", 32'(cyc), 32'd2);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", 32'(er), 32'd0);
        xfer(1, 32'h20, 32'h12345678, 4'hF, 3, 32'h5A5A5A5A, 0, cyc, rd, er, nreq, st);
        chk("wr_lat", 32'(cyc), 32'd5);
        chk("wr_err", 32'(er), 32'd0);
        chk("wr_req_cycles", 32'(nreq), 32'd4);
        chk("wr_stable", 32'(st), 32'd1);
        xfer(0, 32'h22, 32'h0, 4'h0, 0, 32'h11111111, 0, cyc, rd, er, nreq, st);
        chk("mis_lat", 32'(cyc), 32'd1);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_data", rd, 32'd0);
        chk("mis_no_req", 32'(nreq), 32'd0);
        xfer(0, 32'h30, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1, cyc, rd, er, nreq, st);
        chk("slverr_lat", 32'(cyc), 32'd3);
        chk("slverr_err", 32'(er), 32'd1);
        chk("slverr_data", rd, 32'd0);
        xfer(0, 32'h34, 32'h0, 4'h0, 0, 32'h0F0F0F0F, 0, cyc, rd, er, nreq, st);
        chk("b2b_lat", 32'(cyc), 32'd2);
        chk("b2b_data", rd, 32'h0F0F0F0F);
`ifdef REG_BUS_RESP_SLICE_TIMEOUT_EN
        xfer(0, 32'h50, 32'h0, 4'h0, 100, 32'h99999999, 0, cyc, rd, er, nreq, st);
        chk("to_lat", 32'(cyc), 32'd5);
        chk("to_err", 32'(er), 32'd1);
        chk("to_data", rd, 32'd0);
        chk("to_req_cycles", 32'(nreq), 32'd4);
        mst_if.ready = 1;
        repeat (2) @(negedge clk);
        chk("to_late_ready", 32'(slv_if.ready), 32'd0);
        mst_if.ready = 0;
        xfer(0, 32'h54, 32'h0, 4'h0, 3, 32'h76543210, 0, cyc, rd, er, nreq, st);
        chk("to_edge_lat", 32'(cyc), 32'd5);
        chk("to_edge_err", 32'(er), 32'd0);
        chk("to_edge_data", rd, 32'h76543210);
`endif
        @(posedge clk); #1;
        slv_if.valid = 1; slv_if.write = 1; slv_if.addr = 32'h40; slv_if.wdata = 32'hA5A5A5A5; slv_if.wstrb = 4'h3;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_req", 32'(mst_if.valid), 32'd1);
        rst = 1; slv_if.valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        xfer(0, 32'h44, 32'h0, 4'h0, 0, 32'h0BADCAFE, 0, cyc, rd, er, nreq, st);
        chk("post_rst_lat", 32'(cyc), 32'd2);
        chk("post_rst_data", rd, 32'h0BADCAFE);
        chk("post_rst_err", 32'(er), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
